input_event_scheduler: RTL and testbench

Upstream stimulus stage for a generated RTLola monitor (`topEntity`). It accepts timestamped input events from a host over a valid/ready port and buffers them in a FIFO. Each event is released to the monitor as a one-cycle `new_input_0` pulse with its value, on the cycle its timestamp comes due. Between events the value bus is driven to 0. This replaces hand-written `@(posedge clk)` delay scripts in end-to-end tests, and it lets hardware hosts drive the monitor directly.

---
 rtl/input_event_scheduler_pkg.sv | 18 +
 rtl/input_event_scheduler_sync_fifo.sv | 56 +++++
 rtl/input_event_scheduler.sv | 89 ++++++++
 tb/tb_input_event_scheduler.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/input_event_scheduler_pkg.sv
// Shared types and default widths for the input event scheduler.
package scheduler_pkg;

    localparam int DEF_DATA_W = 64;
    localparam int DEF_TIME_W = 48;
    localparam int DEF_DEPTH  = 8;

    // "time" is a reserved word, so the release timestamp field is named timestamp.
    typedef struct packed {
        logic        [DEF_TIME_W-1:0] timestamp;
        logic signed [DEF_DATA_W-1:0] value;
    } event_t;

    function automatic int LEVEL_W(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/input_event_scheduler_sync_fifo.sv
// Synchronous FIFO with wrap-around pointers; the extra pointer MSB separates full from empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic             push_ok;
    logic             pop_ok;

    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign level = wr_ptr_reg - rd_ptr_reg;

    // Head is read asynchronously so the scheduler can compare it in the same cycle.
    assign dout = mem[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/input_event_scheduler.sv
// Buffers timestamped host events and releases each one as a single-cycle strobe
// to the monitor once the free-running cycle counter reaches its timestamp.
module input_event_scheduler
    import scheduler_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int TIME_W = DEF_TIME_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic                        ev_valid,
    output logic                        ev_ready,
    input  logic        [TIME_W-1:0]    ev_time,
    input  logic signed [DATA_W-1:0]    ev_value,
    output logic signed [DATA_W-1:0]    input_0,
    output logic                        new_input_0,
    output logic                        late_0,
    output logic [LEVEL_W(DEPTH)-1:0]   level
);

    typedef struct packed {
        logic        [TIME_W-1:0] timestamp;
        logic signed [DATA_W-1:0] value;
    } ev_t;

    ev_t                       din;
    ev_t                       head;
    logic                      full;
    logic                      empty;
    logic                      push;
    logic                      release_now;
    logic [TIME_W-1:0]         now_reg;
    logic signed [DATA_W-1:0]  input_0_reg;
    logic                      new_input_0_reg;
    logic                      late_0_reg;

    assign din      = {ev_time, ev_value};
    assign ev_ready = !full && !rst;
    assign push     = ev_valid && ev_ready;

    assign release_now = en && !empty && (head.timestamp <= now_reg);

    sync_fifo #(
        .WIDTH ($bits(ev_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (release_now),
        .din   (din),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    // Saturating counter: long runs pin at all-ones rather than wrapping back to early timestamps.
    always_ff @(posedge clk) begin
        if (rst) begin
            now_reg <= '0;
        end else if (en && (now_reg != {TIME_W{1'b1}})) begin
            now_reg <= now_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            input_0_reg     <= '0;
            new_input_0_reg <= 1'b0;
            late_0_reg      <= 1'b0;
        end else if (release_now) begin
            input_0_reg     <= head.value;
            new_input_0_reg <= 1'b1;
            late_0_reg      <= (head.timestamp < now_reg);
        end else begin
            input_0_reg     <= '0;
            new_input_0_reg <= 1'b0;
            late_0_reg      <= 1'b0;
        end
    end

    assign input_0     = input_0_reg;
    assign new_input_0 = new_input_0_reg;
    assign late_0      = late_0_reg;

endmodule

// File: tb/tb_input_event_scheduler.sv
// Directed bench for input_event_scheduler: pulses are logged by a monitor and
// compared against hand-computed release cycles, values and late flags.
module tb_input_event_scheduler;
    import scheduler_pkg::*;

    localparam int DATA_W = 64;
    localparam int TIME_W = 48;
    localparam int DEPTH  = 8;

    logic                        clk = 1'b0;
    logic                        rst;
    logic                        en;
    logic                        ev_valid;
    logic                        ev_ready;
    logic        [TIME_W-1:0]    ev_time;
    logic signed [DATA_W-1:0]    ev_value;
    logic signed [DATA_W-1:0]    input_0;
    logic                        new_input_0;
    logic                        late_0;
    logic [LEVEL_W(DEPTH)-1:0]   level;

    input_event_scheduler #(
        .DATA_W (DATA_W),
        .TIME_W (TIME_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .ev_valid    (ev_valid),
        .ev_ready    (ev_ready),
        .ev_time     (ev_time),
        .ev_value    (ev_value),
        .input_0     (input_0),
        .new_input_0 (new_input_0),
        .late_0      (late_0),
        .level       (level)
    );

    always #5 clk = ~clk;

    // Reference cycle counter, following the counting rule of the design's now.
    logic [TIME_W-1:0] tnow = '0;
    always @(posedge clk) begin
        if (rst) begin
            tnow <= '0;
        end else if (en && (tnow != {TIME_W{1'b1}})) begin
            tnow <= tnow + 1'b1;
        end
    end

    typedef struct {
        longint n;
        longint v;
        bit     l;
    } pulse_t;

    pulse_t pq[$];
    int     idle_bad = 0;

    always @(negedge clk) begin
        if (new_input_0) begin
            pq.push_back('{longint'(tnow), longint'(input_0), late_0});
        end else if ((input_0 != 0) || late_0) begin
            idle_bad <= idle_bad + 1;
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_now(input longint n);
        int k;
        k = 0;
        while ((longint'(tnow) < n) && (k < 5000)) begin
            step();
            k++;
        end
        check("wait_now", longint'(tnow), n);
    endtask

    task automatic push_ev(input longint t, input longint v);
        int k;
        ev_time  = t[TIME_W-1:0];
        ev_value = v;
        ev_valid = 1'b1;
        k = 0;
        @(negedge clk);
        while (!ev_ready && (k < 50)) begin
            @(negedge clk);
            k++;
        end
        check("push_ready", ev_ready, 1);
        $display("push time=%0d value=%0d at now=%0d", t, v, tnow);
        @(posedge clk);
        #1;
        ev_valid = 1'b0;
    endtask

    task automatic take_pulse(input string tag, input longint n, input longint v, input bit l);
        pulse_t p;
        check({tag, "_present"}, pq.size() > 0, 1);
        if (pq.size() > 0) begin
            p = pq.pop_front();
            $display("pulse %s now=%0d value=%0d late=%0d", tag, p.n, p.v, p.l);
            check({tag, "_now"},   p.n, n);
            check({tag, "_value"}, p.v, v);
            check({tag, "_late"},  p.l, l);
        end
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        repeat (cycles) step();
        rst = 1'b0;
        pq.delete();
    endtask

    longint n0;

    initial begin
        rst      = 1'b1;
        en       = 1'b1;
        ev_valid = 1'b0;
        ev_time  = '0;
        ev_value = '0;

        // Reset state
        repeat (2) step();
        check("rst_ready", ev_ready, 0);
        check("rst_level", level, 0);
        check("rst_strobe", new_input_0, 0);
        check("rst_value", input_0, 0);
        rst = 1'b0;
        pq.delete();

        // Single event
        wait_now(3);
        push_ev(1000, 1);
        check("single_level", level, 1);
        wait_now(1003);
        take_pulse("single", 1001, 1, 0);
        check("single_left", pq.size(), 0);
        check("single_level_after", level, 0);

        // Full FIFO
        do_reset(1);
        for (int i = 0; i < 8; i++) begin
            push_ev(100 + i, 1 + i);
        end
        check("full_level", level, 8);
        check("full_ready", ev_ready, 0);
        ev_time  = 48'd500;
        ev_value = 64'sd99;
        ev_valid = 1'b1;
        repeat (3) step();
        check("full_hold_ready", ev_ready, 0);
        check("full_hold_level", level, 8);
        ev_valid = 1'b0;
        wait_now(100);
        check("full_ready_at100", ev_ready, 0);
        wait_now(102);
        check("full_ready_at102", ev_ready, 1);
        wait_now(110);
        for (int i = 0; i < 8; i++) begin
            take_pulse("full", 101 + i, 1 + i, 0);
        end
        check("full_left", pq.size(), 0);

        // Late and duplicate timestamps
        do_reset(1);
        wait_now(50);
        push_ev(5, -3);
        wait_now(60);
        take_pulse("late", 52, -3, 1);
        push_ev(200, 7);
        push_ev(200, 9);
        wait_now(205);
        take_pulse("dup0", 201, 7, 0);
        take_pulse("dup1", 202, 9, 1);
        check("dup_left", pq.size(), 0);

        // Enable gating
        push_ev(305, 42);
        wait_now(300);
        en = 1'b0;
        repeat (10) step();
        check("en_level", level, 1);
        check("en_no_pulse", pq.size(), 0);
        en = 1'b1;
        wait_now(310);
        take_pulse("en", 306, 42, 0);

        // Simultaneous push and pop
        en = 1'b0;
        push_ev(1, 11);
        push_ev(1, 12);
        push_ev(1, 13);
        check("sim_level_pre", level, 3);
        check("sim_no_pulse", pq.size(), 0);
        en       = 1'b1;
        ev_time  = 48'd1;
        ev_value = 64'sd14;
        ev_valid = 1'b1;
        step();
        ev_valid = 1'b0;
        check("sim_level_post", level, 3);
        n0 = longint'(tnow);
        repeat (6) step();
        for (int i = 0; i < 4; i++) begin
            take_pulse("sim", n0 + i, 11 + i, 1);
        end
        check("sim_left", pq.size(), 0);

        // Reset mid-operation
        push_ev(1000, 1);
        push_ev(1001, 2);
        push_ev(1002, 3);
        check("mid_level_pre", level, 3);
        rst = 1'b1;
        step();
        check("mid_level", level, 0);
        check("mid_strobe", new_input_0, 0);
        check("mid_value", input_0, 0);
        check("mid_late", late_0, 0);
        check("mid_ready", ev_ready, 0);
        rst = 1'b0;
        pq.delete();
        push_ev(10, 77);
        wait_now(1010);
        take_pulse("mid", 11, 77, 0);
        check("mid_left", pq.size(), 0);

        check("idle_zero", idle_bad, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
